// File: rtl/minterm_sweep_pkg.sv
// Shared types and sizes for the minterm sweep stimulus block.
package minterm_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  localparam int NUM_MINTERMS = 16;
  localparam int MINTERM_W    = 4;
  localparam int ERR_W        = 5;

endpackage

// File: rtl/minterm_sweeper_dwell_counter.sv
// Hold-time counter: flags the last cycle of each minterm's dwell window.
module dwell_counter #(
  parameter int DWELL = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  logic [7:0] count;

  assign last = (count == 8'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (en)
      count <= last ? '0 : count + 8'd1;
  end

endmodule

// File: rtl/minterm_sweeper.sv
// Sweeps minterms 0..15 into a 4-input block and checks captured truth tables.
// Optional: SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module minterm_sweeper
  import minterm_sweep_pkg::*;
#(
  parameter int          DWELL  = 5,
  parameter logic [15:0] EXP_F1 = 16'h0000,
  parameter logic [15:0] EXP_F2 = 16'h0000,
  parameter logic [15:0] EXP_F3 = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             f1_in,
  input  logic             f2_in,
  input  logic             f3_in,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [15:0]      tt_f1,
  output logic [15:0]      tt_f2,
  output logic [15:0]      tt_f3,
  output logic [ERR_W-1:0] err_cnt,
`ifdef SWEEP_STOP_ON_FAIL_EN
  output logic [3:0]       fail_idx,
`endif
  output logic             pass
);

  sweep_state_t         state;
  logic [MINTERM_W-1:0] m;
  logic                 last;
  logic                 go;
  logic                 miss;
  logic                 stop;

  assign go   = start && (state != DRIVE);
  assign miss = (f1_in != EXP_F1[m]) ||
                (f2_in != EXP_F2[m]) ||
                (f3_in != EXP_F3[m]);

`ifdef SWEEP_STOP_ON_FAIL_EN
  assign stop = (m == 4'hF) || miss;
`else
  assign stop = (m == 4'hF);
`endif

  assign {a, b, c, d} = m;
  assign pass = done && (err_cnt == '0);

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (go),
    .en    (state == DRIVE),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      m        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt_f1    <= '0;
      tt_f2    <= '0;
      tt_f3    <= '0;
      err_cnt  <= '0;
`ifdef SWEEP_STOP_ON_FAIL_EN
      fail_idx <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= DRIVE;
            m        <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            tt_f1    <= '0;
            tt_f2    <= '0;
            tt_f3    <= '0;
            err_cnt  <= '0;
`ifdef SWEEP_STOP_ON_FAIL_EN
            fail_idx <= '0;
`endif
          end
        end
        DRIVE: begin
          if (last) begin
            tt_f1[m] <= f1_in;
            tt_f2[m] <= f2_in;
            tt_f3[m] <= f3_in;
            if (miss)
              err_cnt <= err_cnt + 1'b1;
`ifdef SWEEP_STOP_ON_FAIL_EN
            if (miss)
              fail_idx <= m;
`endif
            if (stop) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              m <= m + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_sweeper.sv
// Directed bench for minterm_sweeper with a table-driven logic model.
module tb_minterm_sweeper;

  localparam logic [15:0] E1 = 16'h8001;
  localparam logic [15:0] E2 = 16'h00FF;
  localparam logic [15:0] E3 = 16'hAAAA;

  logic        clk = 0;
  logic        rst, start;
  logic        f1_in, f2_in, f3_in;
  logic        a, b, c, d, busy, done, pass;
  logic [15:0] tt_f1, tt_f2, tt_f3;
  logic [4:0]  err_cnt;
`ifdef SWEEP_STOP_ON_FAIL_EN
  logic [3:0]  fail_idx;
`endif
  logic [15:0] flip1, flip2;
  logic [3:0]  idx;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n;

  always #5 clk = ~clk;

  minterm_sweeper #(
    .DWELL(5), .EXP_F1(E1), .EXP_F2(E2), .EXP_F3(E3)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .f1_in(f1_in), .f2_in(f2_in), .f3_in(f3_in),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done),
    .tt_f1(tt_f1), .tt_f2(tt_f2), .tt_f3(tt_f3),
    .err_cnt(err_cnt),
`ifdef SWEEP_STOP_ON_FAIL_EN
    .fail_idx(fail_idx),
`endif
    .pass(pass)
  );

  // logic-under-test model with per-minterm fault injection
  assign idx   = {a, b, c, d};
  assign f1_in = E1[idx] ^ flip1[idx];
  assign f2_in = E2[idx] ^ flip2[idx];
  assign f3_in = E3[idx];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    rst = 1; start = 0; flip1 = '0; flip2 = '0;
    tick(); tick();
    rst = 0;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_abcd", {28'd0, a, b, c, d}, 32'd0);
      chk("rst_flags", {29'd0, busy, done, pass}, 32'd0);
      chk("rst_err", {27'd0, err_cnt}, 32'd0);
      chk("rst_tt", {tt_f1 | tt_f2 | tt_f3}, 32'd0);
    end
`ifdef SWEEP_STOP_ON_FAIL_EN
    chk("rst_fidx", {28'd0, fail_idx}, 32'd0);
`endif

`ifndef SWEEP_STOP_ON_FAIL_EN
    // full passing sweep
    pulse_start();
    for (int k = 0; k < 80; k++) begin
      chk("p_abcd", {28'd0, a, b, c, d}, k / 5);
      chk("p_busy_done", {30'd0, busy, done}, 32'd2);
      if (k == 40)
        chk("p_partial_f3", {16'd0, tt_f3}, 32'h00AA);
      tick();
    end
    chk("p_done", {30'd0, busy, done}, 32'd1);
    chk("p_tt1", {16'd0, tt_f1}, 32'h8001);
    chk("p_tt2", {16'd0, tt_f2}, 32'h00FF);
    chk("p_tt3", {16'd0, tt_f3}, 32'hAAAA);
    chk("p_err", {27'd0, err_cnt}, 32'd0);
    chk("p_pass", {31'd0, pass}, 32'd1);
    chk("p_abcd_end", {28'd0, a, b, c, d}, 32'd15);
    tick(); tick();
    chk("p_done_hold", {31'd0, done}, 32'd1);

    // mismatches at 3 and 12, plus ignored start mid-sweep
    flip2 = 16'h1008;
    pulse_start();
    chk("m_done_clr", {30'd0, busy, done}, 32'd2);
    chk("m_err_clr", {27'd0, err_cnt}, 32'd0);
    for (int k = 0; k < 80; k++) begin
      if (k == 40) start = 1;
      if (k == 41) start = 0;
      chk("m_abcd", {28'd0, a, b, c, d}, k / 5);
      chk("m_notdone", {31'd0, done}, 32'd0);
      tick();
    end
    chk("m_done", {30'd0, busy, done}, 32'd1);
    chk("m_tt2", {16'd0, tt_f2}, 32'h10F7);
    chk("m_tt1", {16'd0, tt_f1}, 32'h8001);
    chk("m_err", {27'd0, err_cnt}, 32'd2);
    chk("m_pass", {31'd0, pass}, 32'd0);

    // reset mid-sweep, then clean sweep
    flip2 = '0;
    pulse_start();
    for (int k = 0; k < 30; k++) tick();
    chk("r_mid_abcd", {28'd0, a, b, c, d}, 32'd6);
    rst = 1;
    tick();
    rst = 0;
    chk("r_abcd", {28'd0, a, b, c, d}, 32'd0);
    chk("r_flags", {29'd0, busy, done, pass}, 32'd0);
    chk("r_err", {27'd0, err_cnt}, 32'd0);
    chk("r_tt", {tt_f1 | tt_f2 | tt_f3}, 32'd0);
    tick();
    chk("r_idle", {30'd0, busy, done}, 32'd0);
    pulse_start();
    wait_done(n);
    chk("r_latency", n, 32'd80);
    chk("r_tt1", {16'd0, tt_f1}, 32'h8001);
    chk("r_tt2", {16'd0, tt_f2}, 32'h00FF);
    chk("r_tt3", {16'd0, tt_f3}, 32'hAAAA);
    chk("r_pass", {26'd0, pass, err_cnt}, 32'h20);
`else
    // stop at first failure: F1 wrong at minterm 6
    flip1 = 16'h0040;
    pulse_start();
    wait_done(n);
    chk("s_latency", n, 32'd35);
    chk("s_fidx", {28'd0, fail_idx}, 32'd6);
    chk("s_abcd", {28'd0, a, b, c, d}, 32'd6);
    chk("s_err", {27'd0, err_cnt}, 32'd1);
    chk("s_pass", {31'd0, pass}, 32'd0);
    chk("s_busy", {31'd0, busy}, 32'd0);
    chk("s_tt1", {16'd0, tt_f1}, 32'h0041);
    flip1 = '0;
    pulse_start();
    chk("s_fidx_clr", {28'd0, fail_idx}, 32'd0);
    wait_done(n);
    chk("s_clean_lat", n, 32'd80);
    chk("s_clean_pass", {26'd0, pass, err_cnt}, 32'h20);
    chk("s_clean_fidx", {28'd0, fail_idx}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
